// File: rtl/spi_interface.sv
// Mode-3 SPI byte engine for the PmodACL: shifts out a 16-bit command word MSB first
// and returns the byte received during the second half of the frame.
module spi_interface #(
    parameter int unsigned HALF_PERIOD = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        transmit,
    input  logic [15:0] txdata,
    output logic [7:0]  rxdata,
    output logic        done,
    output logic        busy,
    input  logic        miso,
    output logic        mosi,
    output logic        sclk,
    output logic        ss
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned TXSR_W = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [TXSR_W-1:0]   tx_sr_q, tx_sr_d;
    logic [7:0]          rx_sr_q, rx_sr_d;
    logic [7:0]          rxdata_q, rxdata_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                mosi_q, mosi_d;
    logic                sclk_q, sclk_d;
    logic                ss_q, ss_d;
    logic                miso_s1_q, miso_s1_d;
    logic                miso_s2_q, miso_s2_d;
    logic                phase_end;

    assign phase_end = (cnt_q == CNT_W'(HALF_PERIOD - 1));

    // Next-state and output logic; sclk_q doubles as the low/high phase flag in SHIFT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rxdata_d  = rxdata_q;
        done_d    = done_q;
        busy_d    = busy_q;
        mosi_d    = mosi_q;
        sclk_d    = sclk_q;
        ss_d      = ss_q;
        miso_s1_d = miso;
        miso_s2_d = miso_s1_q;

        case (state_q)
            S_IDLE: begin
                if (transmit) begin
                    tx_sr_d = txdata[14:0];
                    ss_d    = 1'b0;
                    mosi_d  = txdata[15];
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    sclk_d  = 1'b0;
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (!phase_end) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[6:0], miso_s2_q};
                    end else if (bit_q == BIT_W'(15)) begin
                        state_d = S_HOLD;
                    end else begin
                        sclk_d  = 1'b0;
                        mosi_d  = tx_sr_q[14];
                        tx_sr_d = {tx_sr_q[13:0], 1'b0};
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (phase_end) begin
                    cnt_d    = '0;
                    ss_d     = 1'b1;
                    mosi_d   = 1'b0;
                    rxdata_d = rx_sr_q;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rxdata_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            mosi_q    <= 1'b0;
            sclk_q    <= 1'b1;
            ss_q      <= 1'b1;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rxdata_q  <= rxdata_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            mosi_q    <= mosi_d;
            sclk_q    <= sclk_d;
            ss_q      <= ss_d;
            miso_s1_q <= miso_s1_d;
            miso_s2_q <= miso_s2_d;
        end
    end

    assign rxdata = rxdata_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign mosi   = mosi_q;
    assign sclk   = sclk_q;
    assign ss     = ss_q;

endmodule
